// File: rtl/knights_pkg.sv
// Constants and types shared by the Knight's Tour host-side command bridge.
package knights_pkg;

  localparam logic [7:0]  POS_ACK          = 8'hA5;
  localparam logic [15:0] CAL_CMD          = 16'h2000;
  localparam int          DEFAULT_BAUD_DIV = 2604;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/uart_xcvr.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing only clk/rst.
module uart_xcvr #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rx_rdy
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  logic        tx_busy;
  logic [15:0] tx_baud;
  logic [3:0]  tx_bit;
  logic [9:0]  tx_frame;
  logic        tx_tick;

  assign tx_tick = (tx_baud == BAUD_LAST);
  assign tx_done = tx_busy && tx_tick && (tx_bit == 4'd9);
  assign tx      = tx_frame[0];

  // A start request in the last cycle of a stop bit reloads the frame, so
  // consecutive bytes leave the line with no idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_baud  <= 16'd0;
      tx_bit   <= 4'd0;
      tx_frame <= '1;
    end else if (tx_start && (!tx_busy || tx_done)) begin
      tx_busy  <= 1'b1;
      tx_baud  <= 16'd0;
      tx_bit   <= 4'd0;
      tx_frame <= {1'b1, tx_data, 1'b0};
    end else if (tx_busy) begin
      if (tx_tick) begin
        tx_baud <= 16'd0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_frame <= {1'b1, tx_frame[9:1]};
        end
      end else begin
        tx_baud <= tx_baud + 16'd1;
      end
    end
  end

  logic        rx_s1, rx_s2, rx_d;
  logic        rx_busy;
  logic [15:0] rx_baud;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        start_det;
  logic        rx_sample;
  logic        rx_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // rx_bit 0 is the start bit (checked at half a bit), 1..8 data, 9 stop.
  assign start_det = !rx_busy && rx_d && !rx_s2;
  assign rx_sample = rx_busy &&
                     ((rx_bit == 4'd0) ? (rx_baud == HALF_LAST) : (rx_baud == BAUD_LAST));
  assign rx_set    = rx_sample && (rx_bit == 4'd9) && rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_baud  <= 16'd0;
      rx_bit   <= 4'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
    end else if (start_det) begin
      rx_busy <= 1'b1;
      rx_baud <= 16'd0;
      rx_bit  <= 4'd0;
    end else if (rx_busy) begin
      if (rx_sample) begin
        rx_baud <= 16'd0;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
          else       rx_bit  <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          if (rx_s2) rx_data <= rx_shift;
        end else begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_baud <= rx_baud + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          rx_rdy <= 1'b0;
    else if (rx_set)                  rx_rdy <= 1'b1;
    else if (clr_rx_rdy || start_det) rx_rdy <= 1'b0;
  end

endmodule

// File: rtl/remote_comm.sv
// Host command bridge: sends a 16-bit command as two back-to-back UART bytes
// (high first) and presents single-byte responses from the robot.
module remote_comm
  import knights_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  // Handshakes: send_cmd is a one-cycle request honoured only in IDLE; cmd_sent
  // then stays high until the next honoured request. resp_rdy marks resp valid
  // and stays high until a honoured send_cmd or the next incoming start bit.
  cmd_state_t  state, next_state;
  logic [15:0] hold;
  logic        accept;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;

  assign accept = (state == IDLE) && send_cmd;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (send_cmd) next_state = HIGH;
      HIGH:    if (tx_done)  next_state = LOW;
      LOW:     if (tx_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_start = 1'b0;
    tx_data  = cmd[15:8];
    case (state)
      IDLE: tx_start = send_cmd;
      HIGH: begin
        tx_start = tx_done;
        tx_data  = hold[7:0];
      end
      default: tx_data = hold[15:8];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= 16'h0000;
      cmd_sent <= 1'b0;
    end else begin
      if (accept) hold <= cmd;
      if (state == LOW && tx_done) cmd_sent <= 1'b1;
      else if (accept)             cmd_sent <= 1'b0;
    end
  end

  uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk        (clk),
    .rst        (rst),
    .rx         (RX),
    .tx         (TX),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .rx_rdy     (resp_rdy),
    .rx_data    (resp),
    .clr_rx_rdy (accept)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: queue scoreboard with independent TX and response
// monitors, driven by directed and randomized command/response traffic.
module tb_remote_comm;
  import knights_pkg::*;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .send_cmd (send_cmd),
    .cmd_sent (cmd_sent),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] exp_q[$];
  int         tx_starts[$];
  logic [7:0] model_resp = 8'h00;
  int         model_free_at = 0;
  int         last_accept_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic skip(input int n, inout bit abort);
    repeat (n) begin
      @(negedge clk);
      if (rst) abort = 1'b1;
    end
  endtask

  // TX monitor: decodes 8N1 frames off the line, mid-bit, and scores them.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    logic       start_ok, stop_ok;
    bit         abort;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else begin
        if (prev && !TX) begin
          tx_starts.push_back(cyc);
          abort = 1'b0;
          skip(BD / 2 - 1, abort);
          start_ok = !TX;
          for (int i = 0; i < 8; i++) begin
            skip(BD, abort);
            b[i] = TX;
          end
          skip(BD, abort);
          stop_ok = TX;
          if (!abort) begin
            check("tx_start_bit", 32'(start_ok), 32'd1);
            check("tx_stop_bit", 32'(stop_ok), 32'd1);
            if (tx_exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL tx_unexpected_frame: got byte %0h, none expected", b);
            end else begin
              check("tx_byte", 32'(b), 32'(tx_exp_q.pop_front()));
            end
          end
        end
        prev = TX;
      end
    end
  end

  // Response monitor: every rising resp_rdy must match the next expected byte.
  initial begin : rx_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_rdy && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected: got %0h, none expected", resp);
        end else begin
          check("resp_byte", 32'(resp), 32'(exp_q.pop_front()));
        end
      end
      prev = resp_rdy;
    end
  end

  // The model accepts a strobe only once the previous 20-bit command has
  // finished and the bridge has returned to idle.
  task automatic send(input logic [15:0] c);
    bit acc;
    @(negedge clk);
    acc = (cyc >= model_free_at);
    cmd = c;
    send_cmd = 1'b1;
    if (acc) begin
      tx_exp_q.push_back(c[15:8]);
      tx_exp_q.push_back(c[7:0]);
      last_accept_cyc = cyc;
      model_free_at = cyc + 20 * BD + 1;
    end
    @(negedge clk);
    send_cmd = 1'b0;
    cmd = 16'($urandom);
    if (acc) check("cmd_sent_cleared", 32'(cmd_sent), 32'd0);
  endtask

  task automatic wait_sent();
    int n = 0;
    while (!cmd_sent && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_sent_timeout", 32'(cmd_sent), 32'd1);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    if (stop) begin
      exp_q.push_back(b);
      model_resp = b;
    end
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    logic seen;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_tx", 32'(TX), 32'd1);
    check("reset_cmd_sent", 32'(cmd_sent), 32'd0);
    check("reset_resp_rdy", 32'(resp_rdy), 32'd0);
    check("reset_resp", 32'(resp), 32'h00);
    check("reset_fsm", 32'(dut.state), 32'(IDLE));
    seen = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (resp_rdy) seen = 1'b1;
    end
    check("idle_rx_no_resp", 32'(seen), 32'd0);

    // Calibration command; a strobe landing on the completion cycle is dropped.
    send(CAL_CMD);
    n = 0;
    while (cyc < last_accept_cyc + 20 * BD - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_sent_not_early", 32'(cmd_sent), 32'd0);
    send(16'hFFFF);
    check("cmd_sent_at_320", 32'(cmd_sent), 32'd1);
    check("tx_two_frames", 32'(tx_starts.size()), 32'd2);
    if (tx_starts.size() == 2) begin
      check("tx_start_latency", 32'(tx_starts[1] - tx_starts[0]), 32'(10 * BD));
      check("cmd_sent_delay", 32'(cyc - tx_starts[0]), 32'(20 * BD));
    end
    repeat (100) @(negedge clk);
    check("cmd_sent_held", 32'(cmd_sent), 32'd1);

    drive_rx(POS_ACK, 1'b1);
    repeat (50) @(negedge clk);
    check("resp_rdy_held", 32'(resp_rdy), 32'd1);
    check("resp_held", 32'(resp), 32'(model_resp));

    send(16'h1234);
    check("resp_rdy_cleared_by_send", 32'(resp_rdy), 32'd0);
    repeat (48) @(negedge clk);
    send(16'hFFFF);
    wait_sent();
    repeat (200) @(negedge clk);

    drive_rx(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    check("framing_err_rdy", 32'(resp_rdy), 32'd0);
    check("framing_err_resp", 32'(resp), 32'(model_resp));
    @(negedge clk);
    RX = 1'b0;
    repeat (8) @(negedge clk);
    RX = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_rdy", 32'(resp_rdy), 32'd0);
    check("glitch_resp", 32'(resp), 32'(model_resp));

    // Full duplex: random commands and random responses overlap in time.
    fork
      begin
        repeat (4) begin
          send(16'($urandom));
          wait_sent();
          repeat ($urandom_range(0, 20)) @(negedge clk);
        end
      end
      begin
        repeat (6) begin
          repeat ($urandom_range(1, 60)) @(negedge clk);
          drive_rx(8'($urandom), ($urandom_range(0, 3) != 0));
        end
      end
    join
    repeat (200) @(negedge clk);
    check("resp_after_random", 32'(resp), 32'(model_resp));

    // Reset in the middle of the high byte.
    send(16'($urandom));
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(TX), 32'd1);
    check("midrst_cmd_sent", 32'(cmd_sent), 32'd0);
    check("midrst_fsm", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    tx_exp_q.delete();
    tx_starts.delete();
    model_free_at = 0;
    model_resp = 8'h00;
    check("midrst_resp", 32'(resp), 32'(model_resp));
    repeat (200) @(negedge clk);
    send(16'hC35A);
    wait_sent();

    repeat (300) @(negedge clk);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    check("resp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
